branch_resolve_unit: RTL

Execute-stage companion to the fetch-side branch target buffer. It carries each fetch-time prediction (taken bit and predicted next PC) alongside its instruction through the F→D and D→E pipeline registers. In EX it compares that prediction with the actual branch outcome, raises a redirect when they disagree, and drives the predictor update port. It also keeps saturating performance counters for branches and mispredictions. It sits between the BTB, the hazard unit and the EX-stage branch logic.

---
 rtl/bp_pkg.sv | 14 +
 rtl/pred_pipe_reg.sv | 37 +++
 rtl/branch_resolve_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch resolve path: the per-stage prediction record
// carried alongside each instruction, and the sequential PC increment.
package bp_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] npc_pred;
  } pred_rec_t;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/pred_pipe_reg.sv
// One pipeline record of fetch-time prediction state. Flush beats stall and
// clears the whole record so a squashed slot never looks like a real branch.
module pred_pipe_reg
  import bp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_valid,
  input  logic [31:0] i_pc,
  input  logic        i_pred,
  input  logic [31:0] i_npc_pred,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic        o_pred,
  output logic [31:0] o_npc_pred
);

  pred_rec_t r_rec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rec <= '0;
    end else if (i_flush) begin
      r_rec <= '0;
    end else if (!i_stall) begin
      r_rec <= '{valid: i_valid, pc: i_pc, pred: i_pred, npc_pred: i_npc_pred};
    end
  end

  assign o_valid    = r_rec.valid;
  assign o_pc       = r_rec.pc;
  assign o_pred     = r_rec.pred;
  assign o_npc_pred = r_rec.npc_pred;

endmodule

// File: rtl/branch_resolve_unit.sv
// Carries BTB predictions from fetch to EX, detects mispredictions against the
// resolved branch outcome, and keeps saturating branch/mispredict counters.
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PCF,
  input  logic             PredF,
  input  logic [31:0]      NPC_PredF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             IsBrE,
  input  logic             BranchE,
  input  logic [31:0]      BrNPC,
  output logic [31:0]      PCE,
  output logic             PredE,
  output logic [31:0]      NPC_PredE,
  output logic             MispredE,
  output logic [31:0]      RedirectPC,
  output logic [CNT_W-1:0] BrCount,
  output logic [CNT_W-1:0] MispredCount
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic inc);
    if (inc && (cnt != '1)) return cnt + CNT_ONE;
    return cnt;
  endfunction

  logic        w_d_valid;
  logic [31:0] w_d_pc;
  logic        w_d_pred;
  logic [31:0] w_d_npc_pred;
  logic        w_e_valid;
  logic        w_mispred;
  logic        w_retire;
  logic [31:0] w_seq_pc;

  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mis_cnt;

  // F -> D record
  pred_pipe_reg u_rec_d (
    .clk       (clk),
    .rst       (rst),
    .i_stall   (StallD),
    .i_flush   (FlushD),
    .i_valid   (1'b1),
    .i_pc      (PCF),
    .i_pred    (PredF),
    .i_npc_pred(NPC_PredF),
    .o_valid   (w_d_valid),
    .o_pc      (w_d_pc),
    .o_pred    (w_d_pred),
    .o_npc_pred(w_d_npc_pred)
  );

  // D -> E record
  pred_pipe_reg u_rec_e (
    .clk       (clk),
    .rst       (rst),
    .i_stall   (StallE),
    .i_flush   (FlushE),
    .i_valid   (w_d_valid),
    .i_pc      (w_d_pc),
    .i_pred    (w_d_pred),
    .i_npc_pred(w_d_npc_pred),
    .o_valid   (w_e_valid),
    .o_pc      (PCE),
    .o_pred    (PredE),
    .o_npc_pred(NPC_PredE)
  );

  // EX resolve: the correct next PC is always the actual outcome, so the
  // redirect target does not depend on what was predicted.
  assign w_seq_pc   = PCE + PC_INC;
  assign w_mispred  = w_e_valid &&
                      ((PredE != BranchE) || (PredE && BranchE && (NPC_PredE != BrNPC)));
  assign MispredE   = w_mispred;
  assign RedirectPC = BranchE ? BrNPC : w_seq_pc;

  // Counting happens on the edge where the instruction leaves EX, so a held
  // instruction is counted once and a same-cycle FlushE does not hide it.
  assign w_retire = w_e_valid && !StallE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else if (w_retire) begin
      r_br_cnt  <= sat_inc(r_br_cnt, IsBrE);
      r_mis_cnt <= sat_inc(r_mis_cnt, w_mispred);
    end
  end

  assign BrCount      = r_br_cnt;
  assign MispredCount = r_mis_cnt;

endmodule
